control_unit: RTL and testbench
===============================

# control_unit

Fetch/decode front end of the 5-stage ARM-subset pipeline. It holds the 8-bit program counter and the 32-bit IF/ID instruction register, and combinationally decodes the latched instruction into ID-stage control signals. The decoded signals feed the ID-stage NOP mux and then the ID/EX register. PC increment (PC_adder) and instruction ROM are external.

## Interface
- No parameters.
- clk  input  1  rising-edge clock for all state
- R  input  1  synchronous active-high reset
- LE  input  1  load enable for the PC and IF/ID registers (0 = stall/hold)
- in_pc  input  8  next PC value (from external PC adder/branch mux)
- rom_instruction  input  32  instruction fetched at out_pc
- out_pc  output  8  current PC
- instruction  output  32  IF/ID register contents
- opcode  output  4  ALU opcode
- AM  output  1  addressing mode: 1 = immediate operand/offset
- S_enable  output  1  update condition flags
- load_instr  output  1  memory load
- RF_enable  output  1  register file write in WB
- Size_enable  output  1  byte access (0 = word)
- RW_enable  output  1  memory write (1 = store)
- Enable_signal  output  1  data-memory access enable
- BL_instr  output  1  branch-with-link
- B_instr  output  1  branch (set for B and BL)

## Operation
- PC register: on posedge, R=1 -> 0; else LE=1 -> in_pc; else hold.
- IF/ID register: on posedge, R=1 -> 32'h0; else LE=1 -> rom_instruction; else hold.
- Decoder is purely combinational from the IF/ID register `instruction`. The condition field [31:28] is ignored.
- Outputs not listed for a class below are 0.
- instruction == 32'h0: every control output is 0 (NOP).
- Data processing, [27:26]=00:
  - opcode=[24:21], S_enable=[20], AM=[25].
  - RF_enable=1 except for opcodes 1000–1011 (TST/TEQ/CMP/CMN).
- Load/store, [27:26]=01:
  - opcode=0100 if U=[23]=1, else 0010.
  - AM=~[25], Enable_signal=1.
  - load_instr=[20], RF_enable=[20], RW_enable=~[20], Size_enable=[22].
- Branch, [27:25]=101:
  - B_instr=1, opcode=0100.
  - BL_instr=[24], RF_enable=[24] (link write).
- Any other encoding, [27:25]=100, 110 or 111: all outputs 0.

## Timing
- out_pc and instruction update one cycle after the capturing edge. No other latency.
- Control outputs follow `instruction` combinationally within the same cycle.
- R has priority over LE when both are asserted on the same edge.
- After reset, all outputs are 0 from the first post-reset edge.
- Reset asserted mid-stream clears state on the next edge regardless of LE.
- LE=0 freezes out_pc and instruction together, so decoded outputs stay stable.
- out_pc wraps naturally; there is no overflow logic, and the incoming value is used as given.

## Test plan
- Reset: R=1, LE=1, in_pc=8'h10, rom=E0821003, one edge -> out_pc=0, instruction=0, all controls 0.
- ADD: R=0, LE=1, in_pc=8'h04, rom=E0821003, one edge -> out_pc=04, instruction=E0821003, opcode=0100, AM=0, S_enable=0, RF_enable=1, memory signals 0.
- Stall: LE=0, in_pc=8'h08, rom=E3510000, one edge -> out_pc stays 04, instruction stays E0821003, outputs unchanged.
- LDR/STRB, LE=1:
  - rom=E5912004 -> opcode=0100, AM=1, load_instr=1, RF_enable=1, Enable_signal=1, RW_enable=0, Size_enable=0.
  - rom=E5C12000 -> RW_enable=1, Size_enable=1, Enable_signal=1, load_instr=0, RF_enable=0.
- CMP/BL:
  - rom=E3510000 -> opcode=1010, S_enable=1, AM=1, RF_enable=0.
  - rom=EB000010 -> B_instr=1, BL_instr=1, RF_enable=1.
  - rom=EA000010 -> B_instr=1, BL_instr=0, RF_enable=0.
- Reset mid-run: after loading EB000010, assert R with LE=1 for one edge -> out_pc=0, instruction=0, B_instr=0, BL_instr=0.

Source files
------------

// File: rtl/control_unit.sv
// Fetch/decode front end: PC and IF/ID registers plus
// combinational ID-stage control decode of the latched word.
module control_unit (
  input  logic        clk,
  input  logic        R,
  input  logic        LE,
  input  logic [7:0]  in_pc,
  input  logic [31:0] rom_instruction,
  output logic [7:0]  out_pc,
  output logic [31:0] instruction,
  output logic [3:0]  opcode,
  output logic        AM,
  output logic        S_enable,
  output logic        load_instr,
  output logic        RF_enable,
  output logic        Size_enable,
  output logic        RW_enable,
  output logic        Enable_signal,
  output logic        BL_instr,
  output logic        B_instr
);

  logic is_nop;
  logic is_dp;
  logic is_ls;
  logic is_br;
  logic is_cmp_class;

  always_ff @(posedge clk) begin
    if (R) begin
      out_pc      <= 8'h00;
      instruction <= 32'h0;
    end else if (LE) begin
      out_pc      <= in_pc;
      instruction <= rom_instruction;
    end
  end

  // The all-zero word decodes as data processing, so NOP must win first
  assign is_nop = (instruction == 32'h0);
  assign is_dp  = !is_nop && (instruction[27:26] == 2'b00);
  assign is_ls  = !is_nop && (instruction[27:26] == 2'b01);
  assign is_br  = !is_nop && (instruction[27:25] == 3'b101);

  // TST/TEQ/CMP/CMN only set flags
  assign is_cmp_class = (instruction[24:23] == 2'b10);

  always_comb begin
    opcode        = 4'b0000;
    AM            = 1'b0;
    S_enable      = 1'b0;
    load_instr    = 1'b0;
    RF_enable     = 1'b0;
    Size_enable   = 1'b0;
    RW_enable     = 1'b0;
    Enable_signal = 1'b0;
    BL_instr      = 1'b0;
    B_instr       = 1'b0;
    unique case (1'b1)
      is_dp: begin
        opcode    = instruction[24:21];
        S_enable  = instruction[20];
        AM        = instruction[25];
        RF_enable = !is_cmp_class;
      end
      is_ls: begin
        opcode        = instruction[23] ? 4'b0100 : 4'b0010;
        AM            = !instruction[25];
        Enable_signal = 1'b1;
        load_instr    = instruction[20];
        RF_enable     = instruction[20];
        RW_enable     = !instruction[20];
        Size_enable   = instruction[22];
      end
      is_br: begin
        B_instr   = 1'b1;
        opcode    = 4'b0100;
        BL_instr  = instruction[24];
        RF_enable = instruction[24];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: register behaviour and
// decode of each instruction class against hand-computed vectors.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        R;
  logic        LE;
  logic [7:0]  in_pc;
  logic [31:0] rom_instruction;
  logic [7:0]  out_pc;
  logic [31:0] instruction;
  logic [3:0]  opcode;
  logic        AM, S_enable, load_instr, RF_enable;
  logic        Size_enable, RW_enable, Enable_signal;
  logic        BL_instr, B_instr;

  int n_checks = 0;
  int n_errors = 0;

  control_unit dut (
    .clk(clk),
    .R(R),
    .LE(LE),
    .in_pc(in_pc),
    .rom_instruction(rom_instruction),
    .out_pc(out_pc),
    .instruction(instruction),
    .opcode(opcode),
    .AM(AM),
    .S_enable(S_enable),
    .load_instr(load_instr),
    .RF_enable(RF_enable),
    .Size_enable(Size_enable),
    .RW_enable(RW_enable),
    .Enable_signal(Enable_signal),
    .BL_instr(BL_instr),
    .B_instr(B_instr)
  );

  always #5 clk = ~clk;

  // {opcode,AM,S,load,RF,Size,RW,En,BL,B}
  logic [12:0] ctl;
  assign ctl = {opcode, AM, S_enable, load_instr,
                RF_enable, Size_enable, RW_enable,
                Enable_signal, BL_instr, B_instr};

  function automatic logic [12:0] c(
    input logic [3:0] op, input logic am, input logic s,
    input logic ld, input logic rf, input logic sz,
    input logic rw, input logic en, input logic bl,
    input logic b);
    return {op, am, s, ld, rf, sz, rw, en, bl, b};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic le,
                      input logic [7:0] pc,
                      input logic [31:0] rom);
    R = r;
    LE = le;
    in_pc = pc;
    rom_instruction = rom;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag,
                            input logic [7:0] pc,
                            input logic [31:0] ir,
                            input logic [12:0] cv);
    check({tag, ".pc"}, {24'h0, out_pc}, {24'h0, pc});
    check({tag, ".ir"}, instruction, ir);
    check({tag, ".ctl"}, {19'h0, ctl}, {19'h0, cv});
  endtask

  initial begin
    R = 1'b1;
    LE = 1'b1;
    in_pc = 8'h10;
    rom_instruction = 32'hE0821003;
    @(negedge clk);
    step(1, 1, 8'h10, 32'hE0821003);
    expect_all("reset", 8'h00, 32'h0, 13'h0);

    step(0, 1, 8'h04, 32'hE0821003);
    expect_all("add", 8'h04, 32'hE0821003,
               c(4'b0100, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    step(0, 0, 8'h08, 32'hE3510000);
    expect_all("stall", 8'h04, 32'hE0821003,
               c(4'b0100, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    step(0, 1, 8'h08, 32'hE5912004);
    expect_all("ldr", 8'h08, 32'hE5912004,
               c(4'b0100, 1, 0, 1, 1, 0, 0, 1, 0, 0));

    step(0, 1, 8'h0C, 32'hE5C12000);
    expect_all("strb", 8'h0C, 32'hE5C12000,
               c(4'b0100, 1, 0, 0, 0, 1, 1, 1, 0, 0));

    step(0, 1, 8'h10, 32'hE5112004);
    expect_all("ldr_down", 8'h10, 32'hE5112004,
               c(4'b0010, 1, 0, 1, 1, 0, 0, 1, 0, 0));

    step(0, 1, 8'h14, 32'hE3510000);
    expect_all("cmp", 8'h14, 32'hE3510000,
               c(4'b1010, 1, 1, 0, 0, 0, 0, 0, 0, 0));

    step(0, 1, 8'h18, 32'hE0921003);
    expect_all("adds", 8'h18, 32'hE0921003,
               c(4'b0100, 0, 1, 0, 1, 0, 0, 0, 0, 0));

    step(0, 1, 8'h1C, 32'hE1A01002);
    expect_all("mov", 8'h1C, 32'hE1A01002,
               c(4'b1101, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    step(0, 1, 8'h20, 32'hEA000010);
    expect_all("b", 8'h20, 32'hEA000010,
               c(4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    step(0, 1, 8'h24, 32'hE8BD0000);
    expect_all("other100", 8'h24, 32'hE8BD0000, 13'h0);

    step(0, 1, 8'h28, 32'hEE000000);
    expect_all("other111", 8'h28, 32'hEE000000, 13'h0);

    step(0, 1, 8'hFF, 32'h00000000);
    expect_all("nop_pcff", 8'hFF, 32'h0, 13'h0);

    step(0, 1, 8'h00, 32'hEB000010);
    expect_all("bl_wrap", 8'h00, 32'hEB000010,
               c(4'b0100, 0, 0, 0, 1, 0, 0, 0, 1, 1));

    step(0, 1, 8'h30, 32'hEB000010);
    step(1, 1, 8'h34, 32'hE0821003);
    expect_all("reset_mid", 8'h00, 32'h0, 13'h0);

    step(0, 1, 8'h40, 32'hE5C12000);
    step(1, 0, 8'h44, 32'hE0821003);
    expect_all("reset_noLE", 8'h00, 32'h0, 13'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
